// File: rtl/wb_mst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : wb_mst_pkg                                                     |
// | Purpose   : Shared types and constants for the Wishbone burst initiator.   |
// |             Holds the FSM state encoding and the Wishbone B3 cycle-type    |
// |             tags placed on wb_cti_o.                                       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package wb_mst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Cycle type of a beat, given how many beats remain including this one
  // and whether the whole command is a single beat.
  function automatic logic [2:0] beat_cti(input logic single, input logic last);
    if (single)    return CTI_CLASSIC;
    else if (last) return CTI_EOB;
    else           return CTI_INCR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mst_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : wb_mst_pattern                                                 |
// | Purpose   : Data pattern generator and optional read checker. The pattern  |
// |             register is loaded with the command seed and advances by one   |
// |             on every acknowledged beat; its value is the write data and    |
// |             the expected read data of the current beat.                    |
// | Config    : WB_MST_CHECK_EN - when defined, read beats are compared with   |
// |             the pattern on the enabled byte lanes and mismatches counted   |
// |             (saturating). When undefined, o_err_cnt is tied to 0.          |
// | Ports     : clk, rst      clock / synchronous active-high reset            |
// |             i_load        load i_seed into the pattern                     |
// |             i_step        advance the pattern (beat acknowledged)          |
// |             i_check       compare i_rd_dat this cycle (read beat ack)      |
// |             i_sel         byte enables used as compare mask                |
// |             o_pat         current pattern value                            |
// |             o_err_cnt     mismatch count                                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module wb_mst_pattern #(
  parameter int dw = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [dw-1:0]   i_seed,
  input  logic            i_step,
  input  logic            i_check,
  input  logic [dw/8-1:0] i_sel,
  input  logic [dw-1:0]   i_rd_dat,
  output logic [dw-1:0]   o_pat,
  output logic [15:0]     o_err_cnt
);

  logic [dw-1:0] r_pat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= '0;
    end else if (i_load) begin
      r_pat <= i_seed;
    end else if (i_step) begin
      r_pat <= r_pat + 1'b1;
    end
  end

  assign o_pat = r_pat;

`ifdef WB_MST_CHECK_EN
  logic [dw-1:0] w_mask;
  logic          w_mismatch;
  logic [15:0]   r_err_cnt;

  for (genvar g = 0; g < dw/8; g++) begin : g_lane
    assign w_mask[g*8 +: 8] = {8{i_sel[g]}};
  end

  // r_pat still holds the value for the beat being acknowledged.
  assign w_mismatch = |((i_rd_dat ^ r_pat) & w_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (i_check && w_mismatch && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{i_check, i_sel, i_rd_dat};
  assign o_err_cnt    = 16'd0;
`endif

endmodule
`default_nettype wire

// File: rtl/wb_sdr_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : wb_sdr_burst_master                                            |
// | Purpose   : Wishbone B3 incrementing-burst initiator used as a traffic     |
// |             generator / memory-test engine in front of the SDRAM           |
// |             controller. One command = one burst of cmd_len beats.          |
// | Config    : WB_MST_CHECK_EN enables read-data checking (err_cnt).          |
// | Ports     : wb_clk_i, wb_rst_i       clock, sync active-high reset         |
// |             cmd_*                    command handshake and fields          |
// |             wb_*_o / wb_ack_i/dat_i  Wishbone master port                  |
// |             rd_data, rd_valid        read beat stream                      |
// |             done                     1-cycle end-of-command pulse          |
// |             timeout                  sticky ack-timeout flag               |
// |             err_cnt                  read mismatch count                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module wb_sdr_burst_master
  import wb_mst_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int BL_W   = 9,
  parameter int TO_W   = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [BL_W-1:0]   cmd_len,
  input  logic [dw/8-1:0]   cmd_sel,
  input  logic [dw-1:0]     cmd_seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic [dw-1:0]     rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       err_cnt
);

  localparam int              c_lsb     = $clog2(dw/8);
  localparam logic [APP_AW-1:0] c_step  = APP_AW'(dw/8);
  // Counter value on the last tolerated idle cycle: stb stays up for
  // 2**TO_W-1 cycles without an ack before the cycle is abandoned.
  localparam logic [TO_W-1:0] c_to_last = {{(TO_W-1){1'b1}}, 1'b0};

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [APP_AW-1:0]   r_addr;
  logic [dw/8-1:0]     r_sel;
  logic [2:0]          r_cti;
  logic [BL_W-1:0]     r_beat_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [dw-1:0]       r_rd_data;
  logic                r_rd_valid;
  logic                r_done;
  logic                r_timeout;

  logic                w_accept;
  logic                w_ack;
  logic [BL_W-1:0]     w_len_eff;
  logic [APP_AW-1:0]   w_addr_aligned;
  logic [dw-1:0]       w_pat;

  assign w_accept  = (r_state == IDLE) && cmd_valid && r_cmd_ready;
  // Acks outside an active strobe (including late ones after a timeout)
  // are dropped here.
  assign w_ack     = (r_state == BUS) && r_stb && wb_ack_i;
  assign w_len_eff = (cmd_len == '0) ? BL_W'(1) : cmd_len;

  if (c_lsb > 0) begin : g_align
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^cmd_addr[c_lsb-1:0];
    assign w_addr_aligned    = {cmd_addr[APP_AW-1:c_lsb], {c_lsb{1'b0}}};
  end else begin : g_no_align
    assign w_addr_aligned = cmd_addr;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_sel       <= '0;
      r_cti       <= CTI_CLASSIC;
      r_beat_cnt  <= '0;
      r_to_cnt    <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_state     <= BUS;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_we        <= cmd_we;
            r_addr      <= w_addr_aligned;
            r_sel       <= cmd_sel;
            r_beat_cnt  <= w_len_eff;
            r_cti       <= beat_cti(w_len_eff == BL_W'(1), 1'b0);
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
          end
        end

        BUS: begin
          if (w_ack) begin
            r_to_cnt   <= '0;
            r_beat_cnt <= r_beat_cnt - BL_W'(1);
            if (!r_we) begin
              r_rd_data  <= wb_dat_i;
              r_rd_valid <= 1'b1;
            end
            if (r_beat_cnt == BL_W'(1)) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_cti   <= CTI_CLASSIC;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              // Next beat goes out back-to-back; it is the last one when
              // exactly two beats were outstanding before this ack.
              r_addr <= r_addr + c_step;
              r_cti  <= beat_cti(1'b0, r_beat_cnt == BL_W'(2));
            end
          end else if (r_to_cnt == c_to_last) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_cti     <= CTI_CLASSIC;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        DONE: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  wb_mst_pattern #(
    .dw (dw)
  ) u_pattern (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .i_load    (w_accept),
    .i_seed    (cmd_seed),
    .i_step    (w_ack),
    .i_check   (w_ack && !r_we),
    .i_sel     (r_sel),
    .i_rd_dat  (wb_dat_i),
    .o_pat     (w_pat),
    .o_err_cnt (err_cnt)
  );

  assign cmd_ready = r_cmd_ready;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_addr_o = r_addr;
  assign wb_sel_o  = r_sel;
  assign wb_dat_o  = w_pat;
  assign wb_cti_o  = r_cti;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_sdr_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_wb_sdr_burst_master                                         |
// | Purpose   : Self-checking bench for wb_sdr_burst_master. A table of        |
// |             commands with hand-computed first-beat cti and last-beat       |
// |             address is played against a simple acking slave; timeout,      |
// |             stray ack and mid-burst reset are hand-written sequences.      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wb_sdr_burst_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [25:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_seed;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [25:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        timeout;
  logic [15:0] err_cnt;

`ifdef WB_MST_CHECK_EN
  localparam bit C_CHK = 1'b1;
`else
  localparam bit C_CHK = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  wb_sdr_burst_master #(
    .APP_AW (26),
    .dw     (32),
    .BL_W   (9),
    .TO_W   (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_sel   (cmd_sel),
    .cmd_seed  (cmd_seed),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_addr_o (wb_addr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_o  (wb_dat_o),
    .wb_cti_o  (wb_cti_o),
    .wb_ack_i  (wb_ack_i),
    .wb_dat_i  (wb_dat_i),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .timeout   (timeout),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [8:0]  len;
    logic [3:0]  sel;
    logic [31:0] seed;
    int          waits;
    int          bad_beat;
    logic [31:0] bad_mask;
    logic [2:0]  exp_cti0;
    logic [25:0] exp_last_addr;
  } cmd_vec_t;

  cmd_vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (sel[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Entered and left at a negedge with the DUT idle and cmd_ready high.
  task automatic run_cmd(input cmd_vec_t v);
    int          beats;
    logic [25:0] base;
    logic [25:0] a;
    logic [25:0] last_a;
    logic [31:0] rdat;
    logic [2:0]  ecti;
    logic [2:0]  cti_first;
    beats = (v.len == 9'd0) ? 1 : int'(v.len);
    base  = v.addr & 26'h3FFFFFC;
    rdat  = '0;
    last_a = '0;
    cti_first = '0;
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    cmd_sel   = v.sel;
    cmd_seed  = v.seed;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("timeout_clear_on_accept", timeout, 0);
    for (int i = 0; i < beats; i++) begin
      a    = base + 26'(4 * i);
      ecti = (beats == 1) ? 3'b000 : ((i == beats - 1) ? 3'b111 : 3'b010);
      if (i == 0) cti_first = wb_cti_o;
      last_a = wb_addr_o;
      for (int w = 0; w <= v.waits; w++) begin
        chk("cyc", wb_cyc_o, 1);
        chk("stb", wb_stb_o, 1);
        chk("addr", wb_addr_o, a);
        chk("cti", wb_cti_o, ecti);
        chk("we", wb_we_o, v.we);
        chk("sel", wb_sel_o, v.sel);
        if (v.we) chk("wdat", wb_dat_o, v.seed + 32'(i));
        if (w == v.waits) begin
          wb_ack_i = 1'b1;
          rdat     = (v.seed + 32'(i)) ^ ((i == v.bad_beat) ? v.bad_mask : 32'h0);
          wb_dat_i = v.we ? 32'h0 : rdat;
        end
        @(negedge clk);
      end
      wb_ack_i = 1'b0;
      if (!v.we) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, rdat);
        if (C_CHK && (i == v.bad_beat) && ((v.bad_mask & lane_mask(v.sel)) != 0)) exp_err++;
      end else begin
        chk("rd_valid_write", rd_valid, 0);
      end
    end
    chk("cti_first", cti_first, v.exp_cti0);
    chk("last_addr", last_a, v.exp_last_addr);
    chk("cyc_after_last", wb_cyc_o, 0);
    chk("stb_after_last", wb_stb_o, 0);
    chk("done_pulse", done, 1);
    chk("cmd_ready_in_done", cmd_ready, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("err_cnt", err_cnt, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    cmd_vec_t v;
    //           we    addr         len    sel     seed          waits bad mask           cti0    last addr
    vecs[0] = '{1'b1, 26'h0000100, 9'd4, 4'hF,  32'h000000A0, 0, -1, 32'h0,        3'b010, 26'h000010C};
    vecs[1] = '{1'b0, 26'h0000040, 9'd1, 4'hF,  32'h00000055, 3, -1, 32'h0,        3'b000, 26'h0000040};
    vecs[2] = '{1'b0, 26'h0000200, 9'd8, 4'h3,  32'h00001000, 0,  5, 32'h00000100, 3'b010, 26'h000021C};
    vecs[3] = '{1'b0, 26'h0000300, 9'd8, 4'h3,  32'h00002000, 1,  5, 32'hFF000000, 3'b010, 26'h000031C};
    vecs[4] = '{1'b1, 26'h3FFFFFC, 9'd2, 4'hF,  32'h00000007, 0, -1, 32'h0,        3'b010, 26'h0000000};
    vecs[5] = '{1'b1, 26'h0000013, 9'd0, 4'h5,  32'h00000009, 2, -1, 32'h0,        3'b000, 26'h0000010};
    vecs[6] = '{1'b0, 26'h0000400, 9'd3, 4'hC,  32'hFFFFFFFE, 2, -1, 32'h0,        3'b010, 26'h0000408};

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_sel = '0; cmd_seed = '0; wb_ack_i = 1'b0; wb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_addr", wb_addr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_cti", wb_cti_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    for (int k = 0; k < 7; k++) run_cmd(vecs[k]);

    // Slave never acks: strobe must stay up exactly 2**4-1 cycles.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h800; cmd_len = 9'd3;
    cmd_sel = 4'hF; cmd_seed = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && wb_stb_o; k++) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_stb_cycles", cnt, 15);
    chk("to_flag", timeout, 1);
    chk("to_done", done, 1);
    chk("to_cyc", wb_cyc_o, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD0000;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("late_ack_rd_valid", rd_valid, 0);
    chk("late_ack_done", done, 0);
    chk("to_sticky", timeout, 1);
    chk("to_cmd_ready", cmd_ready, 1);
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("idle_ack_rd_valid", rd_valid, 0);
    chk("idle_ack_stb", wb_stb_o, 0);
    chk("to_sticky_idle", timeout, 1);
    v = '{1'b1, 26'h0000020, 9'd1, 4'hF, 32'h00000033, 0, -1, 32'h0, 3'b000, 26'h0000020};
    run_cmd(v);
    chk("to_cleared", timeout, 0);

    // Reset while beat 2 of a 6-beat write is on the bus.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 26'h1000; cmd_len = 9'd6;
    cmd_sel = 4'hF; cmd_seed = 32'h50;
    @(negedge clk);
    cmd_valid = 1'b0;
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("rst_burst_beat2_stb", wb_stb_o, 1);
    chk("rst_burst_beat2_addr", wb_addr_o, 26'h1004);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cyc", wb_cyc_o, 0);
    chk("midrst_stb", wb_stb_o, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    exp_err = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", cmd_ready, 1);
    chk("midrst_release_done", done, 0);
    chk("midrst_release_cyc", wb_cyc_o, 0);

    run_cmd(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
